// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: op codes and FSM states shared by the ALU sequencer
package alu_op_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_OP_NONE   = 4'b0000,
        GET_WORD_IN   = 4'b0001,
        MUX_WORD_OUT  = 4'b0010,
        LAST_WORD_OUT = 4'b0100
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, GET, MUX, LAST} seq_state_t;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: job, word-stream and datapath-op signals of the sequencer
interface alu_op_sequencer_if import alu_op_sequencer_pkg::*; #(parameter int CW = 8);
    logic          start;
    logic          abort;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    alu_op_t       alu_op;
    logic          busy;
    logic          done;
    modport master (
        output start, abort, in_count, out_count, in_valid, out_ready,
        input  in_ready, out_valid, out_last, alu_op, busy, done
    );
    modport slave (
        input  start, abort, in_count, out_count, in_valid, out_ready,
        output in_ready, out_valid, out_last, alu_op, busy, done
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences word-serial ALU ops (get words, mux words, last word) per job
module alu_op_sequencer import alu_op_sequencer_pkg::*; #(
    parameter int CW = 8
) (
    input logic               clk,
    input logic               reset,
    alu_op_sequencer_if.slave bus
);
    seq_state_t    state;
    logic [CW-1:0] in_rem;
    logic [CW-1:0] out_rem;
    assign bus.in_ready  = state == GET;
    assign bus.out_valid = state == MUX || state == LAST;
    assign bus.out_last  = state == LAST;
    assign bus.busy      = state != IDLE;
    // FSM, word counters and the one-cycle-delayed op/done outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_rem     <= '0;
            out_rem    <= '0;
            bus.alu_op <= ALU_OP_NONE;
            bus.done   <= 1'b0;
        end else begin
            bus.alu_op <= ALU_OP_NONE;
            bus.done   <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state   <= IDLE;
                in_rem  <= '0;
                out_rem <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        in_rem  <= bus.in_count;
                        out_rem <= (bus.out_count == '0) ? CW'(1) : bus.out_count;
                        state   <= (bus.in_count != '0) ? GET :
                                   (bus.out_count > CW'(1)) ? MUX : LAST;
                    end
                    GET: if (bus.in_valid) begin
                        in_rem     <= in_rem - CW'(1);
                        bus.alu_op <= GET_WORD_IN;
                        if (in_rem == CW'(1)) state <= (out_rem > CW'(1)) ? MUX : LAST;
                    end
                    MUX: if (bus.out_ready) begin
                        out_rem    <= out_rem - CW'(1);
                        bus.alu_op <= MUX_WORD_OUT;
                        if (out_rem == CW'(2)) state <= LAST;
                    end
                    LAST: if (bus.out_ready) begin
                        out_rem    <= '0;
                        bus.alu_op <= LAST_WORD_OUT;
                        bus.done   <= 1'b1;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for the ALU op sequencer
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;
    int   ng, nm, nl, nd, nr;
    alu_op_sequencer_if #(.CW(8)) bus ();
    alu_op_sequencer #(.CW(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic do_start(input logic [7:0] ic, input logic [7:0] oc);
        bus.in_count  = ic;
        bus.out_count = oc;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
    endtask
    task automatic run_job(input int max, output int g, output int m, output int l, output int d, output int r);
        g = 0; m = 0; l = 0; d = 0; r = 0;
        for (int i = 0; i < max; i++) begin
            if (bus.in_ready) r++;
            step();
            if (bus.alu_op == 4'b0001) g++;
            if (bus.alu_op == 4'b0010) m++;
            if (bus.alu_op == 4'b0100) l++;
            if (bus.done) d++;
            if (!bus.busy) return;
        end
        check("job_timeout_busy", bus.busy, 0);
    endtask
    initial begin
        logic [3:0] exp_ops [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
        reset = 1'b1;
        bus.start = 0; bus.abort = 0; bus.in_count = 0; bus.out_count = 0;
        bus.in_valid = 0; bus.out_ready = 0;
        step(); step();
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        reset = 1'b0;
        step();
        bus.in_valid = 1; bus.out_ready = 1;
        do_start(3, 2);
        check("basic_first_none", bus.alu_op, 0);
        check("basic_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("basic_op%0d", i), bus.alu_op, exp_ops[i]);
            check($sformatf("basic_done%0d", i), bus.done, i == 4);
            check($sformatf("basic_busy%0d", i), bus.busy, i != 4);
        end
        step();
        check("basic_after_none", bus.alu_op, 0);
        do_start(0, 0);
        check("zero_in_ready", bus.in_ready, 0);
        check("zero_out_valid", bus.out_valid, 1);
        check("zero_out_last", bus.out_last, 1);
        step();
        check("zero_op", bus.alu_op, 4'b0100);
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        step();
        bus.out_ready = 0;
        do_start(1, 3);
        step();
        check("bp_get", bus.alu_op, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_stall_op%0d", i), bus.alu_op, 0);
            check($sformatf("bp_stall_ov%0d", i), bus.out_valid, 1);
        end
        bus.out_ready = 1;
        step(); check("bp_mux0", bus.alu_op, 4'b0010);
        step(); check("bp_mux1", bus.alu_op, 4'b0010);
        step(); check("bp_last", bus.alu_op, 4'b0100);
        check("bp_done", bus.done, 1);
        step();
        bus.in_valid = 0;
        do_start(2, 1);
        bus.in_count = 7; bus.out_count = 5; bus.start = 1;
        step();
        bus.start = 0;
        check("sb_no_op", bus.alu_op, 0);
        bus.in_valid = 1;
        run_job(50, ng, nm, nl, nd, nr);
        check("sb_get", ng, 2);
        check("sb_mux", nm, 0);
        check("sb_last", nl, 1);
        check("sb_done", nd, 1);
        step();
        do_start(5, 1);
        ng = 0; nd = 0;
        step(); if (bus.alu_op == 4'b0001) ng++;
        step(); if (bus.alu_op == 4'b0001) ng++;
        bus.abort = 1;
        step();
        bus.abort = 0;
        check("ab_op", bus.alu_op, 0);
        check("ab_busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done) nd++;
            if (bus.alu_op == 4'b0001) ng++;
        end
        check("ab_gets", ng, 2);
        check("ab_done", nd, 0);
        bus.out_ready = 0;
        do_start(1, 4);
        step();
        check("rm_in_mux", bus.out_valid, 1);
        check("rm_get_op", bus.alu_op, 4'b0001);
        #2 reset = 1;
        #1;
        check("rm_op", bus.alu_op, 0);
        check("rm_busy", bus.busy, 0);
        check("rm_out_valid", bus.out_valid, 0);
        step();
        reset = 0;
        bus.out_ready = 1;
        step();
        do_start(255, 1);
        run_job(400, ng, nm, nl, nd, nr);
        check("big_get", ng, 255);
        check("big_mux", nm, 0);
        check("big_last", nl, 1);
        check("big_done", nd, 1);
        check("big_in_ready_cycles", nr, 255);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
